// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: redirect request, instruction-memory port and decode handshake.
// The master side is the fetch unit; the slave side is memory/decode/PC-update.
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 8,
    parameter int INSTR_WIDTH = 32
);
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;
    logic                   imem_en;
    logic [PC_WIDTH-3:0]    imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    instr_pc;
    logic                   misalign_err;

    modport master (
        input  redirect_valid, redirect_pc, imem_rdata, instr_ready,
        output imem_en, imem_addr, instr_valid, instr, instr_pc, misalign_err
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_rdata, instr_ready,
        input  imem_en, imem_addr, instr_valid, instr, instr_pc, misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads a synchronous imem and hands words
// to decode through a 2-entry queue, with stall backpressure and redirect/flush.
module fetch_unit #(
    parameter int                  PC_WIDTH    = 8,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    logic [PC_WIDTH-1:0]    pc_reg, pc_next;
    logic [1:0]             occ_reg, occ_next;
    logic                   inflight_reg, inflight_next;
    logic [PC_WIDTH-1:0]    inflight_pc_reg, inflight_pc_next;
    logic                   misalign_reg, misalign_next;
    logic [INSTR_WIDTH-1:0] q_instr_reg [2];
    logic [INSTR_WIDTH-1:0] q_instr_next [2];
    logic [PC_WIDTH-1:0]    q_pc_reg [2];
    logic [PC_WIDTH-1:0]    q_pc_next [2];

    logic       pop;
    logic       push;
    logic       issue;
    logic [2:0] in_use;
    logic [1:0] occ_after_pop;

    assign pop           = (occ_reg != 2'd0) & bus.instr_ready;
    assign push          = inflight_reg;
    // Slots already committed: queued words plus the word still coming back.
    assign in_use        = {1'b0, occ_reg} + {2'b00, inflight_reg};
    assign issue         = rst_n & ~bus.redirect_valid & ((in_use < 3'd2) | pop);
    assign occ_after_pop = occ_reg - {1'b0, pop};

    assign bus.imem_en      = issue;
    assign bus.imem_addr    = pc_reg[PC_WIDTH-1:2];
    assign bus.instr_valid  = (occ_reg != 2'd0);
    assign bus.instr        = q_instr_reg[0];
    assign bus.instr_pc     = q_pc_reg[0];
    assign bus.misalign_err = misalign_reg;

    always_comb begin
        pc_next          = pc_reg;
        occ_next         = occ_reg;
        inflight_next    = 1'b0;
        inflight_pc_next = inflight_pc_reg;
        misalign_next    = misalign_reg;
        q_instr_next     = q_instr_reg;
        q_pc_next        = q_pc_reg;

        if (bus.redirect_valid) begin
            // Flush: queued words and the word returning this cycle are discarded.
            pc_next  = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
            occ_next = 2'd0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                misalign_next = 1'b1;
            end
        end else begin
            if (issue) begin
                inflight_next    = 1'b1;
                inflight_pc_next = pc_reg;
                pc_next          = pc_reg + PC_WIDTH'(4);
            end
            if (pop) begin
                q_instr_next[0] = q_instr_reg[1];
                q_pc_next[0]    = q_pc_reg[1];
            end
            // The returning word lands behind whatever survives this cycle's pop.
            if (push) begin
                q_instr_next[occ_after_pop[0]] = bus.imem_rdata;
                q_pc_next[occ_after_pop[0]]    = inflight_pc_reg;
            end
            occ_next = occ_after_pop + {1'b0, push};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_reg          <= RESET_PC;
            occ_reg         <= 2'd0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            misalign_reg    <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                q_instr_reg[i] <= '0;
                q_pc_reg[i]    <= '0;
            end
        end else begin
            pc_reg          <= pc_next;
            occ_reg         <= occ_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
            misalign_reg    <= misalign_next;
            for (int i = 0; i < 2; i++) begin
                q_instr_reg[i] <= q_instr_next[i];
                q_pc_reg[i]    <= q_pc_next[i];
            end
        end
    end
endmodule
